// File: rtl/rpc2_ctrl_axi_wr_data_packer.sv
// AXI W-channel front end: packs narrow/unaligned beats into {valid, strb, data}
// words for the WDAT FIFO, tracks burst length against WLAST and drains bad bursts.
module rpc2_ctrl_axi_wr_data_packer #(
   parameter int unsigned C_AXI_DATA_WIDTH     = 32,
   parameter int unsigned C_AXI_LEN_WIDTH      = 8,
   parameter int unsigned WDAT_FIFO_DATA_WIDTH = C_AXI_DATA_WIDTH + 2 * (C_AXI_DATA_WIDTH / 8)
) (
   input  logic                                  clk,
   input  logic                                  reset_n,
   input  logic                                  cmd_valid,
   output logic                                  cmd_ready,
   input  logic [C_AXI_LEN_WIDTH-1:0]            cmd_len,
   input  logic [2:0]                            cmd_size,
   input  logic                                  cmd_fixed,
   input  logic [$clog2(C_AXI_DATA_WIDTH/8)-1:0] cmd_addr,
   input  logic [C_AXI_DATA_WIDTH-1:0]           AXI_WDATA,
   input  logic [C_AXI_DATA_WIDTH/8-1:0]         AXI_WSTRB,
   input  logic                                  AXI_WLAST,
   input  logic                                  AXI_WVALID,
   output logic                                  AXI_WREADY,
   input  logic                                  wdat_full,
   output logic                                  wdat_wr_en,
   output logic [WDAT_FIFO_DATA_WIDTH-1:0]       wdat_din,
   output logic                                  wready_done,
   output logic                                  wlast_err
);

   localparam int unsigned DW = C_AXI_DATA_WIDTH;
   localparam int unsigned NB = DW / 8;
   localparam int unsigned LB = $clog2(NB);
   localparam int unsigned PW = LB + 1;
   localparam int unsigned LW = C_AXI_LEN_WIDTH;
   localparam int unsigned WF = WDAT_FIFO_DATA_WIDTH;

   typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_DRAIN} state_e;

   state_e          state_q, state_d;
   logic [LW-1:0]   len_q, len_d, beat_cnt_q, beat_cnt_d;
   logic            fixed_q, fixed_d;
   logic [2:0]      esz_q, esz_d;
   logic [LB-1:0]   ptr_q, ptr_d;
   logic [NB-1:0]   acc_valid_q, acc_valid_d, acc_strb_q, acc_strb_d;
   logic [DW-1:0]   acc_data_q, acc_data_d;
   logic [NB-1:0]   out_valid_q, out_valid_d, out_strb_q, out_strb_d;
   logic [DW-1:0]   out_data_q, out_data_d;
   logic            out_v_q, out_v_d;

   logic            wready, beat_acc, data_beat, final_beat, emit, push;
   logic [2:0]      esz_in;
   logic [LB-1:0]   addr_mask;
   logic [PW-1:0]   bpb, ptr_end;
   logic [NB-1:0]   lane_m, mrg_valid, mrg_strb;
   logic [DW-1:0]   mrg_data;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (cmd_valid) state_d = ST_DATA;
         ST_DATA:  if (data_beat && (AXI_WLAST || final_beat))
                      state_d = AXI_WLAST ? ST_IDLE : ST_DRAIN;
         ST_DRAIN: if (beat_acc && AXI_WLAST) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Handshakes and burst-termination flags
   always_comb begin
      cmd_ready = 1'b0;
      wready    = 1'b0;
      case (state_q)
         ST_IDLE:  cmd_ready = 1'b1;
         ST_DATA:  wready    = ~out_v_q | ~wdat_full;
         ST_DRAIN: wready    = 1'b1;
         default:  ;
      endcase
      beat_acc    = AXI_WVALID & wready;
      data_beat   = beat_acc & (state_q == ST_DATA);
      final_beat  = (beat_cnt_q == len_q);
      emit        = data_beat & (fixed_q | (ptr_end == PW'(NB)) | final_beat | AXI_WLAST);
      wready_done = data_beat & (final_beat | AXI_WLAST);
      wlast_err   = data_beat & (final_beat ^ AXI_WLAST);
   end

   assign push       = out_v_q & ~wdat_full;
   assign AXI_WREADY = wready;
   assign wdat_wr_en = push;
   assign wdat_din   = WF'({out_valid_q, out_strb_q, out_data_q});

   // Lane selection and merge of the current beat into the accumulator
   always_comb begin
      esz_in    = (cmd_size > 3'(LB)) ? 3'(LB) : cmd_size;
      addr_mask = LB'((PW'(1) << esz_in) - PW'(1));
      bpb       = PW'(1) << esz_q;
      ptr_end   = PW'(ptr_q) + bpb;
      lane_m    = '0;
      mrg_valid = acc_valid_q;
      mrg_strb  = acc_strb_q;
      mrg_data  = acc_data_q;
      for (int unsigned i = 0; i < NB; i++) begin
         lane_m[i]    = (PW'(i) >= PW'(ptr_q)) && (PW'(i) < ptr_end);
         mrg_valid[i] = acc_valid_q[i] | lane_m[i];
         mrg_strb[i]  = acc_strb_q[i] | (lane_m[i] & AXI_WSTRB[i]);
         if (lane_m[i] && AXI_WSTRB[i]) mrg_data[8*i +: 8] = AXI_WDATA[8*i +: 8];
      end
   end

   always_comb begin
      len_d       = len_q;
      beat_cnt_d  = beat_cnt_q;
      fixed_d     = fixed_q;
      esz_d       = esz_q;
      ptr_d       = ptr_q;
      acc_valid_d = acc_valid_q;
      acc_strb_d  = acc_strb_q;
      acc_data_d  = acc_data_q;
      out_valid_d = out_valid_q;
      out_strb_d  = out_strb_q;
      out_data_d  = out_data_q;
      out_v_d     = out_v_q;
      if (push) out_v_d = 1'b0;
      if (state_q == ST_IDLE && cmd_valid) begin
         len_d      = cmd_len;
         fixed_d    = cmd_fixed;
         esz_d      = esz_in;
         ptr_d      = cmd_addr & ~addr_mask;
         beat_cnt_d = '0;
      end
      if (data_beat) begin
         if (emit) begin
            out_valid_d = mrg_valid;
            out_strb_d  = mrg_strb;
            out_data_d  = mrg_data;
            out_v_d     = 1'b1;
            acc_valid_d = '0;
            acc_strb_d  = '0;
            acc_data_d  = '0;
         end else begin
            acc_valid_d = mrg_valid;
            acc_strb_d  = mrg_strb;
            acc_data_d  = mrg_data;
         end
         if (!fixed_q) ptr_d = LB'(ptr_end);
         beat_cnt_d = beat_cnt_q + LW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         len_q       <= '0;
         beat_cnt_q  <= '0;
         fixed_q     <= 1'b0;
         esz_q       <= '0;
         ptr_q       <= '0;
         acc_valid_q <= '0;
         acc_strb_q  <= '0;
         acc_data_q  <= '0;
         out_valid_q <= '0;
         out_strb_q  <= '0;
         out_data_q  <= '0;
         out_v_q     <= 1'b0;
      end else begin
         len_q       <= len_d;
         beat_cnt_q  <= beat_cnt_d;
         fixed_q     <= fixed_d;
         esz_q       <= esz_d;
         ptr_q       <= ptr_d;
         acc_valid_q <= acc_valid_d;
         acc_strb_q  <= acc_strb_d;
         acc_data_q  <= acc_data_d;
         out_valid_q <= out_valid_d;
         out_strb_q  <= out_strb_d;
         out_data_q  <= out_data_d;
         out_v_q     <= out_v_d;
      end
   end

endmodule

// File: tb/tb_rpc2_ctrl_axi_wr_data_packer.sv
// Bench for rpc2_ctrl_axi_wr_data_packer: directed and random bursts against a
// byte-array reference model, with FIFO pushes collected by a monitor.
module tb_rpc2_ctrl_axi_wr_data_packer;

   localparam int unsigned DW = 32;
   localparam int unsigned NB = DW / 8;
   localparam int unsigned LB = 2;
   localparam int unsigned LW = 8;
   localparam int unsigned WF = DW + 2 * NB;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          cmd_valid, cmd_ready, cmd_fixed;
   logic [LW-1:0] cmd_len;
   logic [2:0]    cmd_size;
   logic [LB-1:0] cmd_addr;
   logic [DW-1:0] AXI_WDATA;
   logic [NB-1:0] AXI_WSTRB;
   logic          AXI_WLAST, AXI_WVALID, AXI_WREADY;
   logic          wdat_full, wdat_wr_en, wready_done, wlast_err;
   logic [WF-1:0] wdat_din;

   rpc2_ctrl_axi_wr_data_packer #(
      .C_AXI_DATA_WIDTH(DW), .C_AXI_LEN_WIDTH(LW), .WDAT_FIFO_DATA_WIDTH(WF)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
      .cmd_size(cmd_size), .cmd_fixed(cmd_fixed), .cmd_addr(cmd_addr),
      .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB), .AXI_WLAST(AXI_WLAST),
      .AXI_WVALID(AXI_WVALID), .AXI_WREADY(AXI_WREADY),
      .wdat_full(wdat_full), .wdat_wr_en(wdat_wr_en), .wdat_din(wdat_din),
      .wready_done(wready_done), .wlast_err(wlast_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cycle = 0;
   int full_mode = 0;
   int hold_until = 0;
   int acc_beats = 0;
   int snap_acc = -1;
   logic snap_rdy = 1'bx;
   bit gaps = 0;

   logic [DW-1:0] bdata[$];
   logic [NB-1:0] bstrb[$];
   bit            blast[$];
   logic [WF-1:0] exp_q[$];
   logic [WF-1:0] got_q[$];

   always @(negedge clk) if (wdat_wr_en === 1'b1) got_q.push_back(wdat_din);

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; inputs change 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
      cycle++;
      if (full_mode == 1) wdat_full = ($urandom_range(0, 2) == 0);
      else if (full_mode == 2 && cycle == hold_until) begin
         snap_acc  = acc_beats;
         snap_rdy  = AXI_WREADY;
         wdat_full = 1'b0;
         full_mode = 0;
      end
   endtask

   task automatic add_beat(input logic [DW-1:0] d, input logic [NB-1:0] s, input bit l);
      bdata.push_back(d);
      bstrb.push_back(s);
      blast.push_back(l);
   endtask

   task automatic clear_beats();
      bdata.delete();
      bstrb.delete();
      blast.delete();
   endtask

   // Reference model: walks byte lanes of each beat and closes words per the burst rules
   function automatic int build_exp(input int len, input int size, input int addr, input bit fixed);
      int esz, bpb, pos;
      bit v[NB];
      bit s[NB];
      logic [7:0] d[NB];
      logic [WF-1:0] w;
      esz = (size > LB) ? LB : size;
      bpb = 1 << esz;
      pos = addr & ~(bpb - 1);
      for (int b = 0; b < NB; b++) begin v[b] = 0; s[b] = 0; d[b] = 8'h00; end
      for (int k = 0; k < bdata.size(); k++) begin
         bit term;
         term = blast[k] || (k == len);
         for (int b = pos; b < pos + bpb; b++) begin
            v[b] = 1;
            if (bstrb[k][b]) begin s[b] = 1; d[b] = bdata[k][8*b +: 8]; end
         end
         if (fixed || (pos + bpb == NB) || term) begin
            w = '0;
            for (int b = 0; b < NB; b++) begin
               w[DW + NB + b] = v[b];
               w[DW + b]      = s[b];
               w[8*b +: 8]    = d[b];
               v[b] = 0; s[b] = 0; d[b] = 8'h00;
            end
            exp_q.push_back(w);
         end
         if (!fixed) pos = (pos + bpb) % NB;
         if (term) return k;
      end
      return -1;
   endfunction

   task automatic send_cmd(input int len, input int size, input int addr, input bit fixed);
      int cyc;
      bit rdy;
      cyc = 0;
      rdy = 0;
      cmd_valid = 1'b1;
      cmd_len   = LW'(len);
      cmd_size  = 3'(size);
      cmd_addr  = LB'(addr);
      cmd_fixed = fixed;
      while (!rdy && cyc < 50) begin
         @(negedge clk);
         rdy = cmd_ready;
         tick();
         cyc++;
      end
      cmd_valid = 1'b0;
      check("cmd_accept", 64'(rdy), 64'd1);
   endtask

   task automatic run_burst(input string tag, input int len, input int size, input int addr, input bit fixed);
      int term;
      term = build_exp(len, size, addr, fixed);
      send_cmd(len, size, addr, fixed);
      for (int k = 0; k < bdata.size(); k++) begin
         bit rdy, dn, er;
         int cyc;
         if (gaps) repeat ($urandom_range(0, 2)) tick();
         AXI_WVALID = 1'b1;
         AXI_WDATA  = bdata[k];
         AXI_WSTRB  = bstrb[k];
         AXI_WLAST  = blast[k];
         rdy = 0; dn = 0; er = 0; cyc = 0;
         while (!rdy && cyc < 100) begin
            @(negedge clk);
            rdy = AXI_WREADY;
            dn  = wready_done;
            er  = wlast_err;
            tick();
            cyc++;
         end
         AXI_WVALID = 1'b0;
         AXI_WLAST  = 1'b0;
         acc_beats++;
         check($sformatf("%s_b%0d_accept", tag, k), 64'(rdy), 64'd1);
         check($sformatf("%s_b%0d_done", tag, k), 64'(dn), 64'(k == term));
         check($sformatf("%s_b%0d_err", tag, k), 64'(er),
               64'((k == term) && !(blast[k] && k == len)));
      end
   endtask

   task automatic drain_and_compare(input string tag);
      full_mode = 0;
      wdat_full = 1'b0;
      repeat (4) tick();
      check($sformatf("%s_nwords", tag), 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("%s_w%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
      check({tag, "_wready"}, 64'(AXI_WREADY), 64'd0);
      check({tag, "_wr_en"}, 64'(wdat_wr_en), 64'd0);
      check({tag, "_din"}, 64'(wdat_din), 64'd0);
      check({tag, "_done"}, 64'(wready_done), 64'd0);
      check({tag, "_err"}, 64'(wlast_err), 64'd0);
   endtask

   initial begin
      reset_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0; cmd_size = '0; cmd_fixed = 1'b0;
      cmd_addr = '0; AXI_WDATA = '0; AXI_WSTRB = '0; AXI_WLAST = 1'b0; AXI_WVALID = 1'b0;
      wdat_full = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("por");
      reset_n = 1'b1;
      tick();

      // Single full-width beat, push the following cycle
      clear_beats();
      add_beat(32'h11223344, 4'hF, 1);
      run_burst("single", 0, 2, 0, 0);
      @(negedge clk);
      check("single_wr_en_next", 64'(wdat_wr_en), 64'd1);
      check("single_din_next", 64'(wdat_din), 64'({4'hF, 4'hF, 32'h11223344}));
      tick();
      drain_and_compare("single");

      // Narrow byte beats packed into one word
      clear_beats();
      add_beat(32'h0000AA00, 4'h2, 0);
      add_beat(32'h00BB0000, 4'h0, 0);
      add_beat(32'hCC000000, 4'h8, 1);
      run_burst("narrow", 2, 0, 1, 0);
      full_mode = 0; wdat_full = 1'b0;
      repeat (3) tick();
      check("narrow_word", 64'(got_q[0]), 64'({4'hE, 4'hA, 32'hCC00AA00}));
      drain_and_compare("narrow");

      // FIXED burst keeps the same lanes every beat
      clear_beats();
      add_beat(32'h12345678, 4'hC, 0);
      add_beat(32'h9ABCDEF0, 4'hC, 1);
      run_burst("fixed", 1, 1, 2, 1);
      full_mode = 0; wdat_full = 1'b0;
      repeat (3) tick();
      check("fixed_w0", 64'(got_q[0]), 64'({4'hC, 4'hC, 32'h12340000}));
      check("fixed_w1", 64'(got_q[1]), 64'({4'hC, 4'hC, 32'h9ABC0000}));
      drain_and_compare("fixed");

      // FIFO full for the whole burst, released later
      clear_beats();
      for (int k = 0; k < 4; k++) add_beat($urandom, 4'hF, k == 3);
      wdat_full  = 1'b1;
      full_mode  = 2;
      hold_until = cycle + 12;
      acc_beats  = 0;
      run_burst("bp", 3, 2, 0, 0);
      check("bp_beats_while_full", 64'(snap_acc), 64'd1);
      check("bp_wready_while_full", 64'(snap_rdy), 64'd0);
      drain_and_compare("bp");

      // Early WLAST on second beat of a four-beat burst
      clear_beats();
      add_beat(32'h000000A1, 4'h1, 0);
      add_beat(32'h0000B200, 4'h2, 1);
      run_burst("early", 3, 0, 0, 0);
      @(negedge clk);
      check("early_idle", 64'(cmd_ready), 64'd1);
      tick();
      drain_and_compare("early");

      // Missing WLAST, then two stray beats drained
      clear_beats();
      add_beat(32'h01010101, 4'hF, 0);
      add_beat(32'h02020202, 4'hF, 0);
      add_beat(32'h03030303, 4'hF, 0);
      add_beat(32'h04040404, 4'hF, 1);
      run_burst("miss", 1, 2, 0, 0);
      @(negedge clk);
      check("miss_idle", 64'(cmd_ready), 64'd1);
      tick();
      drain_and_compare("miss");

      // Randomised bursts with random FIFO backpressure and valid gaps
      for (int t = 0; t < 40; t++) begin
         int len, size, addr, kind, n;
         bit fx;
         len  = $urandom_range(0, 7);
         size = $urandom_range(0, 3);
         addr = $urandom_range(0, NB - 1);
         fx   = ($urandom_range(0, 3) == 0);
         kind = $urandom_range(0, 5);
         if (kind == 0 && len > 0) n = $urandom_range(1, len);
         else if (kind == 1)       n = len + 1 + $urandom_range(1, 3);
         else                      n = len + 1;
         clear_beats();
         for (int k = 0; k < n; k++) add_beat($urandom, NB'($urandom), k == n - 1);
         full_mode = 1;
         gaps = 1;
         run_burst($sformatf("rnd%0d", t), len, size, addr, fx);
         gaps = 0;
         drain_and_compare($sformatf("rnd%0d", t));
      end

      // Reset mid-burst while a word is pending behind a full FIFO
      full_mode = 0;
      wdat_full = 1'b1;
      send_cmd(3, 2, 0, 0);
      AXI_WVALID = 1'b1; AXI_WDATA = 32'hDEADBEEF; AXI_WSTRB = 4'hF; AXI_WLAST = 1'b0;
      @(negedge clk);
      check("rst_beat_ready", 64'(AXI_WREADY), 64'd1);
      tick();
      AXI_WVALID = 1'b0;
      @(negedge clk);
      check("rst_pending_stall", 64'(AXI_WREADY), 64'd0);
      check("rst_pending_no_push", 64'(wdat_wr_en), 64'd0);
      #2 reset_n = 1'b0;
      #1 check_reset_outputs("rst");
      wdat_full = 1'b0;
      #1 check("rst_no_push_in_reset", 64'(wdat_wr_en), 64'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (6) tick();
      check("rst_no_push_after", 64'(got_q.size()), 64'd0);
      check("rst_idle_after", 64'(cmd_ready), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rpc2_ctrl_axi_wr_data_packer.md
Name: rpc2_ctrl_axi_wr_data_packer

Overview:
AXI write-data front end that owns W-channel flow control (drives AXI_WREADY) for one outstanding burst descriptor at a time. It packs narrow and unaligned beats into full-width words of {valid, strb, data} and pushes them into the WDAT FIFO. Width is generalised to 32/64/128 bits. It counts beats against the burst length, checks WLAST against that count, and drains malformed bursts. It sits between the AXI slave W channel and the WDAT FIFO write port, in the single AXI clock domain.

Parameters:
C_AXI_DATA_WIDTH, 32, W data width; legal values 32, 64, 128; NB = C_AXI_DATA_WIDTH/8, LB = log2(NB)
C_AXI_LEN_WIDTH, 8, width of burst length field (beats-1)
WDAT_FIFO_DATA_WIDTH, C_AXI_DATA_WIDTH+2*NB, FIFO word = {valid[NB], strb[NB], data[DW]}

Ports:
clk  in  1  AXI clock, single clock domain
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  burst descriptor valid
cmd_ready  out  1  descriptor accepted when cmd_valid&cmd_ready
cmd_len  in  C_AXI_LEN_WIDTH  beats-1
cmd_size  in  3  log2 bytes per beat
cmd_fixed  in  1  FIXED burst
cmd_addr  in  LB  start address low bits
AXI_WDATA  in  DW  write data
AXI_WSTRB  in  NB  byte strobes
AXI_WLAST  in  1  last beat
AXI_WVALID  in  1  beat valid
AXI_WREADY  out  1  beat ready
wdat_full  in  1  FIFO full
wdat_wr_en  out  1  FIFO push
wdat_din  out  WDAT_FIFO_DATA_WIDTH  FIFO word
wready_done  out  1  one-cycle pulse on the terminating beat of a burst
wlast_err  out  1  one-cycle pulse on a WLAST/count mismatch

Behaviour:
- Reset: FSM=IDLE; cmd_ready=1; AXI_WREADY=0; wdat_wr_en=0; wdat_din=0; wready_done=0; wlast_err=0; acc and out registers cleared; out_v=0.
- Reset mid-burst: the partial word and the pending out word are discarded; no FIFO push after reset deasserts until a new descriptor arrives.
- FSM IDLE: cmd_ready=1.
  - On cmd_valid, latch len, fixed, esz = min(cmd_size, LB), ptr = cmd_addr & ~((1<<esz)-1), and beat_cnt=0.
  - Go to DATA.
- FSM DATA: cmd_ready=0.
  - AXI_WREADY = ~out_v | ~wdat_full.
  - Accepted beat = AXI_WVALID & AXI_WREADY.
- Per accepted beat:
  - lane mask m = ((1<<(1<<esz))-1) << ptr.
  - Byte i with m[i]: valid[i]=1. If AXI_WSTRB[i], strb[i]=1 and data byte i = WDATA byte i.
  - Strobes outside m are ignored.
  - Merge into acc.
- A beat is emitting when any of these holds: fixed=1; ptr+(1<<esz)==NB; final beat (beat_cnt==len); AXI_WLAST=1.
  - On an emitting beat, out <= acc merged with the beat, out_v <= 1, and acc clears.
  - Otherwise acc keeps the merge.
  - ptr <= fixed ? ptr : (ptr+(1<<esz)) mod NB.
  - beat_cnt increments.
- Output and latency:
  - wdat_din = out.
  - wdat_wr_en = out_v & ~wdat_full.
  - out_v clears on push unless it is reloaded in the same cycle.
  - An emitting beat accepted in cycle N gives wdat_wr_en in cycle N+1 if the FIFO is not full.
  - Push and reload in the same cycle are legal and preserve order.
- Burst termination:
  - Final beat with WLAST=1: wready_done pulse, go to IDLE.
  - WLAST=1 with beat_cnt<len (early): word emitted, wready_done and wlast_err pulse, go to IDLE.
  - Final beat with WLAST=0: word emitted, wready_done and wlast_err pulse, go to DRAIN.
- FSM DRAIN: AXI_WREADY=1. Beats are accepted and discarded (no FIFO push). On an accepted WLAST beat, go to IDLE.
- IDLE accepts the next descriptor in the cycle after DATA/DRAIN exits. A pending out word still drains while in IDLE.
- cmd_size>LB: clamped to LB; no error signalled.

Test Plan:
- DW=32, cmd len=0 size=2 addr=0; one beat WDATA=0x11223344 WSTRB=F WLAST=1 -> next cycle wdat_wr_en=1, wdat_din={F,F,0x11223344}; wready_done pulse with the beat; wlast_err=0.
- Narrow packing: len=2 size=0 addr=1; beats on lanes 1,2,3 with WSTRB=2,0,8, data 0xAA00,0xBB0000,0xCC000000 -> single push after beat 3, valid=E, strb=A, data=0xCC00AA00.
- Fixed: len=1 size=1 addr=2 fixed=1; two beats WSTRB=C -> two pushes, each valid=C, strb=C; ptr stays at 2.
- Backpressure: wdat_full=1 throughout a len=3 size=2 burst -> exactly 1 beat accepted, then AXI_WREADY=0. Release full -> all 4 words pushed in order, no loss.
- Early WLAST at beat 2 of len=3 -> partial word pushed, wready_done and wlast_err pulse together, FSM returns to IDLE.
- Missing WLAST on len=1, then 2 stray beats ending with WLAST -> wlast_err on beat 2; stray beats accepted with no push; IDLE after the stray WLAST beat.
- Reset: assert reset_n low mid-burst with out_v=1 -> no push afterwards; all outputs return to reset values.
